// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction-timer core: FSM encoding, LFSR taps,
// and counter-limit helper.
package reaction_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LIGHTS = 3'd1,
    S_WAIT   = 3'd2,
    S_FAULT  = 3'd3,
    S_TIMING = 3'd4
  } state_e;

  // Maximal-length Fibonacci tap masks (bit positions are exponent-1).
  function automatic logic [15:0] lfsr_taps(int unsigned w);
    case (w)
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h0060;
    endcase
  endfunction

  function automatic int unsigned cnt_max(int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/reaction_timer_core_if.sv
// Player/board-facing signal bundle of the reaction-timer core.
interface reaction_timer_core_if #(
  parameter int unsigned N_LIGHTS = 10,
  parameter int unsigned CNT_W    = 14
);
  logic                start;
  logic                react;
  logic [N_LIGHTS-1:0] lights;
  logic [CNT_W-1:0]    rt_ms;
  logic                rt_valid;
  logic [CNT_W-1:0]    best_ms;
  logic                false_start;
  logic                busy;

  modport master (
    output start, react,
    input  lights, rt_ms, rt_valid, best_ms, false_start, busy
  );

  modport slave (
    input  start, react,
    output lights, rt_ms, rt_valid, best_ms, false_start, busy
  );
endinterface

// File: rtl/lfsr_prng.sv
// Free-running Fibonacci LFSR; seeded to 1 on reset so it never locks at zero.
module lfsr_prng
  import reaction_pkg::*;
#(
  parameter int unsigned LFSR_W = 7
) (
  input  logic              CLOCK_50,
  input  logic              rst,
  output logic [LFSR_W-1:0] q
);

  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));

  logic [LFSR_W-1:0] q_q, q_d;

  always_comb begin
    q_d = {q_q[LFSR_W-2:0], ^(q_q & TAPS)};
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) q_q <= LFSR_W'(1);
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/reaction_timer_core.sv
// Reaction-time game engine: light build-up, random hold, lights-out, ms timing,
// false-start detection and best-time tracking.
module reaction_timer_core
  import reaction_pkg::*;
#(
  parameter int unsigned CLK_PER_MS    = 50000,
  parameter int unsigned N_LIGHTS      = 10,
  parameter int unsigned STEP_MS       = 500,
  parameter int unsigned LFSR_W        = 7,
  parameter int unsigned MIN_DELAY_MS  = 250,
  parameter int unsigned DELAY_STEP_MS = 16,
  parameter int unsigned CNT_W         = 14
) (
  input logic                  CLOCK_50,
  input logic                  rst,
  reaction_timer_core_if.slave bus
);

  localparam int unsigned PS_W      = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam int unsigned MAX_DELAY = MIN_DELAY_MS + ((32'd1 << LFSR_W) - 32'd1) * DELAY_STEP_MS;
  localparam int unsigned MS_MAX    = (MAX_DELAY > STEP_MS) ? MAX_DELAY : STEP_MS;
  localparam int unsigned MS_W      = $clog2(MS_MAX + 1);
  localparam logic [CNT_W-1:0] RT_MAX = CNT_W'(cnt_max(CNT_W));
  localparam logic [CNT_W-1:0] RT_SAT = RT_MAX - 1'b1;

  state_e              state_q, state_d;
  logic [N_LIGHTS-1:0] lights_q, lights_d;
  logic [MS_W-1:0]     ms_q, ms_d;
  logic [MS_W-1:0]     delay_q, delay_d;
  logic [CNT_W-1:0]    rt_cnt_q, rt_cnt_d;
  logic [PS_W-1:0]     pre_q, pre_d;
  logic [CNT_W-1:0]    rt_ms_q, rt_ms_d;
  logic                rt_valid_q, rt_valid_d;
  logic [CNT_W-1:0]    best_q, best_d;
  logic                false_start_q, false_start_d;
  logic                busy_q, busy_d;
  logic                start_q, react_q;
  logic [LFSR_W-1:0]   lfsr_q;
  logic                start_e, react_e, tick;

  lfsr_prng #(.LFSR_W(LFSR_W)) u_lfsr (
    .CLOCK_50 (CLOCK_50),
    .rst      (rst),
    .q        (lfsr_q)
  );

  assign start_e = bus.start & ~start_q;
  assign react_e = bus.react & ~react_q;
  assign tick    = (pre_q == PS_W'(CLK_PER_MS - 1));

  always_comb begin
    state_d    = state_q;
    lights_d   = lights_q;
    ms_d       = ms_q;
    delay_d    = delay_q;
    rt_cnt_d   = rt_cnt_q;
    rt_ms_d    = rt_ms_q;
    rt_valid_d = 1'b0;
    best_d     = best_q;
    pre_d      = tick ? '0 : pre_q + 1'b1;

    case (state_q)
      S_IDLE, S_FAULT: begin
        lights_d = (state_q == S_FAULT) ? '1 : '0;
        if (start_e) begin
          state_d  = S_LIGHTS;
          lights_d = N_LIGHTS'(1);
          ms_d     = '0;
          pre_d    = '0;
        end
      end
      S_LIGHTS: begin
        if (react_e) begin
          state_d  = S_FAULT;
          lights_d = '1;
        end else if (tick) begin
          if (ms_q == MS_W'(STEP_MS - 1)) begin
            ms_d = '0;
            if (lights_q == '1) begin
              state_d = S_WAIT;
              delay_d = MS_W'(MIN_DELAY_MS + 32'(lfsr_q) * DELAY_STEP_MS);
            end else begin
              lights_d = {lights_q[N_LIGHTS-2:0], 1'b1};
            end
          end else begin
            ms_d = ms_q + 1'b1;
          end
        end
      end
      S_WAIT: begin
        // A press on the lights-out edge itself still counts as a false start.
        if (react_e) begin
          state_d  = S_FAULT;
          lights_d = '1;
        end else if (tick) begin
          if (ms_q + 1'b1 == delay_q) begin
            state_d  = S_TIMING;
            lights_d = '0;
            pre_d    = '0;
            rt_cnt_d = '0;
          end else begin
            ms_d = ms_q + 1'b1;
          end
        end
      end
      S_TIMING: begin
        if (tick && rt_cnt_q == RT_SAT) begin
          state_d    = S_IDLE;
          rt_cnt_d   = RT_MAX;
          rt_ms_d    = RT_MAX;
          rt_valid_d = 1'b1;
        end else if (react_e) begin
          state_d    = S_IDLE;
          rt_ms_d    = rt_cnt_q;
          rt_valid_d = 1'b1;
          if (rt_cnt_q < best_q) best_d = rt_cnt_q;
        end else if (tick) begin
          rt_cnt_d = rt_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    false_start_d = (state_d == S_FAULT);
    busy_d        = (state_d == S_LIGHTS) || (state_d == S_WAIT) || (state_d == S_TIMING);
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_q       <= S_IDLE;
      lights_q      <= '0;
      ms_q          <= '0;
      delay_q       <= '0;
      rt_cnt_q      <= '0;
      pre_q         <= '0;
      rt_ms_q       <= '0;
      rt_valid_q    <= 1'b0;
      best_q        <= '1;
      false_start_q <= 1'b0;
      busy_q        <= 1'b0;
      start_q       <= 1'b0;
      react_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      lights_q      <= lights_d;
      ms_q          <= ms_d;
      delay_q       <= delay_d;
      rt_cnt_q      <= rt_cnt_d;
      pre_q         <= pre_d;
      rt_ms_q       <= rt_ms_d;
      rt_valid_q    <= rt_valid_d;
      best_q        <= best_d;
      false_start_q <= false_start_d;
      busy_q        <= busy_d;
      start_q       <= bus.start;
      react_q       <= bus.react;
    end
  end

  assign bus.lights      = lights_q;
  assign bus.rt_ms       = rt_ms_q;
  assign bus.rt_valid    = rt_valid_q;
  assign bus.best_ms     = best_q;
  assign bus.false_start = false_start_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_reaction_timer_core.sv
// Directed bench for reaction_timer_core with a 4-cycle ms, 3 lights, 6-bit counters.
module tb_reaction_timer_core;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  reaction_timer_core_if #(.N_LIGHTS(3), .CNT_W(6)) bus ();

  reaction_timer_core #(
    .CLK_PER_MS    (4),
    .N_LIGHTS      (3),
    .STEP_MS       (2),
    .LFSR_W        (7),
    .MIN_DELAY_MS  (2),
    .DELAY_STEP_MS (1),
    .CNT_W         (6)
  ) dut (
    .CLOCK_50 (clk),
    .rst      (rst),
    .bus      (bus)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Advance until lights go dark while busy (TIMING entered); bounded.
  task automatic wait_lo(output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < 3000; i++) begin
      if (bus.busy && bus.lights == 3'b000) begin
        ok = 1'b1;
        break;
      end
      step(1);
      n++;
    end
  endtask

  task automatic press_start();
    bus.start = 1'b0;
    step(1);
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; bus.react = 1'b0;
    step(3);
    n_cmp++; if (bus.lights !== 3'b000) begin n_bad++; $display("FAIL rst_lights: got %b want 000", bus.lights); end
    n_cmp++; if (bus.rt_ms !== 6'd0) begin n_bad++; $display("FAIL rst_rt_ms: got %0d want 0", bus.rt_ms); end
    n_cmp++; if (bus.rt_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rt_valid: got %b want 0", bus.rt_valid); end
    n_cmp++; if (bus.best_ms !== 6'd63) begin n_bad++; $display("FAIL rst_best: got %0d want 63", bus.best_ms); end
    n_cmp++; if (bus.false_start !== 1'b0) begin n_bad++; $display("FAIL rst_false_start: got %b want 0", bus.false_start); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_lights();
    bus.start = 1'b1;
    step(1);
    n_cmp++; if (bus.lights !== 3'b001) begin n_bad++; $display("FAIL lights_1: got %b want 001", bus.lights); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL lights_busy1: got %b want 1", bus.busy); end
    step(7);
    n_cmp++; if (bus.lights !== 3'b001) begin n_bad++; $display("FAIL lights_1_hold: got %b want 001", bus.lights); end
    step(1);
    n_cmp++; if (bus.lights !== 3'b011) begin n_bad++; $display("FAIL lights_2: got %b want 011", bus.lights); end
    step(8);
    n_cmp++; if (bus.lights !== 3'b111) begin n_bad++; $display("FAIL lights_3: got %b want 111", bus.lights); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL lights_busy3: got %b want 1", bus.busy); end
  endtask

  // Round already started; react 'cyc' cycles after lights-out is seen.
  task automatic finish_round(input string nm, input int cyc, input logic [5:0] exp_rt, input logic [5:0] exp_best);
    bit ok; int n;
    wait_lo(ok, n);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL %s_lights_out: timed out, got lights %b want 000", nm, bus.lights); end
    step(cyc);
    n_cmp++; if (bus.rt_valid !== 1'b0) begin n_bad++; $display("FAIL %s_early_valid: got %b want 0", nm, bus.rt_valid); end
    bus.react = 1'b1;
    step(1);
    n_cmp++; if (bus.rt_valid !== 1'b1) begin n_bad++; $display("FAIL %s_valid: got %b want 1", nm, bus.rt_valid); end
    n_cmp++; if (bus.rt_ms !== exp_rt) begin n_bad++; $display("FAIL %s_rt_ms: got %0d want %0d", nm, bus.rt_ms, exp_rt); end
    n_cmp++; if (bus.best_ms !== exp_best) begin n_bad++; $display("FAIL %s_best: got %0d want %0d", nm, bus.best_ms, exp_best); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL %s_busy: got %b want 0", nm, bus.busy); end
    bus.react = 1'b0;
    step(1);
    n_cmp++; if (bus.rt_valid !== 1'b0) begin n_bad++; $display("FAIL %s_valid_once: got %b want 0", nm, bus.rt_valid); end
  endtask

  task automatic test_rounds();
    finish_round("round1", 20, 6'd5, 6'd5);
    press_start();
    finish_round("round2", 12, 6'd3, 6'd3);
    press_start();
    finish_round("round3", 28, 6'd7, 6'd3);
  endtask

  task automatic test_false_start();
    bus.start = 1'b1;
    step(1);
    step(8);
    n_cmp++; if (bus.lights !== 3'b011) begin n_bad++; $display("FAIL fs_pre_lights: got %b want 011", bus.lights); end
    bus.react = 1'b1;
    step(1);
    n_cmp++; if (bus.false_start !== 1'b1) begin n_bad++; $display("FAIL fs_flag: got %b want 1", bus.false_start); end
    n_cmp++; if (bus.lights !== 3'b111) begin n_bad++; $display("FAIL fs_lights: got %b want 111", bus.lights); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL fs_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.rt_ms !== 6'd7) begin n_bad++; $display("FAIL fs_rt_ms: got %0d want 7", bus.rt_ms); end
    bus.react = 1'b0;
    press_start();
    n_cmp++; if (bus.false_start !== 1'b0) begin n_bad++; $display("FAIL fs_clear: got %b want 0", bus.false_start); end
    n_cmp++; if (bus.lights !== 3'b001) begin n_bad++; $display("FAIL fs_restart_lights: got %b want 001", bus.lights); end
  endtask

  task automatic test_timeout();
    bit ok; int n;
    wait_lo(ok, n);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL to_lights_out: timed out, got lights %b want 000", bus.lights); end
    step(251);
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL to_busy_pre: got %b want 1", bus.busy); end
    step(1);
    n_cmp++; if (bus.rt_ms !== 6'd63) begin n_bad++; $display("FAIL to_rt_ms: got %0d want 63", bus.rt_ms); end
    n_cmp++; if (bus.rt_valid !== 1'b1) begin n_bad++; $display("FAIL to_valid: got %b want 1", bus.rt_valid); end
    n_cmp++; if (bus.best_ms !== 6'd3) begin n_bad++; $display("FAIL to_best: got %0d want 3", bus.best_ms); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL to_idle: got %b want 0", bus.busy); end
    step(1);
    n_cmp++; if (bus.rt_valid !== 1'b0) begin n_bad++; $display("FAIL to_valid_once: got %b want 0", bus.rt_valid); end
  endtask

  task automatic test_react_held();
    bit ok; int n;
    bus.start = 1'b1; bus.react = 1'b1;
    step(1);
    n_cmp++; if (bus.lights !== 3'b001) begin n_bad++; $display("FAIL held_start_wins: got %b want 001", bus.lights); end
    wait_lo(ok, n);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL held_lights_out: timed out, got lights %b want 000", bus.lights); end
    step(30);
    n_cmp++; if (bus.busy !== 1'b1 || bus.false_start !== 1'b0) begin n_bad++; $display("FAIL held_still_timing: got busy %b fs %b want 1 0", bus.busy, bus.false_start); end
    bus.react = 1'b0;
    step(1);
    bus.react = 1'b1;
    step(1);
    n_cmp++; if (bus.rt_ms !== 6'd7 || bus.rt_valid !== 1'b1) begin n_bad++; $display("FAIL held_release_rt: got %0d/%b want 7/1", bus.rt_ms, bus.rt_valid); end
    bus.react = 1'b0; bus.start = 1'b0;
    step(1);
  endtask

  task automatic test_reset_mid();
    bit ok; int n;
    press_start();
    wait_lo(ok, n);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rm_lights_out: timed out, got lights %b want 000", bus.lights); end
    step(10);
    rst = 1'b1;
    step(1);
    n_cmp++; if (bus.best_ms !== 6'd63) begin n_bad++; $display("FAIL rm_best: got %0d want 63", bus.best_ms); end
    n_cmp++; if (bus.rt_ms !== 6'd0 || bus.rt_valid !== 1'b0) begin n_bad++; $display("FAIL rm_rt: got %0d/%b want 0/0", bus.rt_ms, bus.rt_valid); end
    n_cmp++; if (bus.busy !== 1'b0 || bus.lights !== 3'b000 || bus.false_start !== 1'b0) begin n_bad++; $display("FAIL rm_state: got busy %b lights %b fs %b want 0 000 0", bus.busy, bus.lights, bus.false_start); end
    rst = 1'b0;
    bus.react = 1'b1;
    step(1);
    bus.react = 1'b0;
    step(1);
    n_cmp++; if (bus.rt_valid !== 1'b0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL rm_no_event: got valid %b busy %b want 0 0", bus.rt_valid, bus.busy); end
  endtask

  task automatic test_busy_start();
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    step(2);
    bus.start = 1'b1;
    step(6);
    n_cmp++; if (bus.lights !== 3'b011) begin n_bad++; $display("FAIL busy_start_ignored: got %b want 011", bus.lights); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL busy_start_busy: got %b want 1", bus.busy); end
    bus.start = 1'b0;
  endtask

  // Two identical runs from reset share the LFSR sequence, so the first run
  // locates the lights-out edge and the second presses exactly on it.
  task automatic test_lights_out_react();
    bit ok; int n;
    bus.start = 1'b0; bus.react = 1'b0;
    rst = 1'b1; step(2); rst = 1'b0; step(3);
    bus.start = 1'b1; step(1);
    wait_lo(ok, n);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL lo_probe: timed out, got lights %b want 000", bus.lights); end
    bus.start = 1'b0;
    rst = 1'b1; step(2); rst = 1'b0; step(3);
    bus.start = 1'b1; step(1);
    step(n - 1);
    bus.react = 1'b1;
    step(1);
    n_cmp++; if (bus.false_start !== 1'b1) begin n_bad++; $display("FAIL lo_fault: got %b want 1", bus.false_start); end
    n_cmp++; if (bus.lights !== 3'b111 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL lo_fault_state: got lights %b busy %b want 111 0", bus.lights, bus.busy); end
    n_cmp++; if (bus.rt_valid !== 1'b0) begin n_bad++; $display("FAIL lo_no_valid: got %b want 0", bus.rt_valid); end
    bus.react = 1'b0; bus.start = 1'b0;
    step(1);
  endtask

  initial begin
    test_reset();
    test_lights();
    test_rounds();
    test_false_start();
    test_timeout();
    test_react_held();
    test_reset_mid();
    test_busy_start();
    test_lights_out_react();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
